// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e : arbiter sequencing states
//   owner_e : which requester owns the current access
//   ADDR_W / DATA_W : memory bus widths
//   cnt_w() : width of a down-counter holding 0..n-1 (never below 1 bit)
package dmem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter used to time the memory wait states of one access.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load WAIT_CYCLES-1 (takes priority over dec)
//   dec      : decrement, holding at zero
//   cnt      : current count
//   zero     : count is zero (final wait cycle of an access)
module dmem_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter  int WAIT_CYCLES = 1,
    localparam int CW          = cnt_w(WAIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the pipeline MEM stage (CPU) and
// a secondary master (DMA). Every access holds address/data for WAIT_CYCLES
// cycles, writes once in the last of them, then spends one completion cycle
// in DONE. CPU has priority, but after STARVE_LIMIT consecutive CPU grants
// with the DMA waiting, the DMA wins the next arbitration.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         MEM-stage request (held while stalled)
//   cpu_rdata, cpu_stall          load data; pipeline freeze (combinational)
//   dma_req/we/addr/wdata         DMA request (held until dma_ack)
//   dma_rdata, dma_ack            read data; one-cycle completion pulse
//   mem_addr/wdata/we, mem_rdata  DataMem interface (combinational read)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = cnt_w(WAIT_CYCLES);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // With a single wait cycle the write strobe must already be set on grant.
    localparam logic LOAD_IS_LAST = (WAIT_CYCLES == 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              dma_ack_q, dma_ack_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]     cnt;
    logic              cpu_win;

    dmem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    // mem_addr/mem_wdata double as the latched access registers: they load on
    // grant and otherwise hold, which also gives the hold-last-value behaviour.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        dma_ack_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cpu_win     = cpu_req && (!dma_req || (starve_q < STARVE_MAX));

        unique case (state_q)
            IDLE: begin
                if (!dma_req) begin
                    starve_d = '0;
                end
                if (cpu_win) begin
                    owner_d     = OWN_CPU;
                    we_d        = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_we_d    = cpu_we && LOAD_IS_LAST;
                    state_d     = BUSY;
                    cnt_load    = 1'b1;
                    // cpu_win with dma_req implies starve_q < limit: no overflow.
                    if (dma_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (dma_req) begin
                    owner_d     = OWN_DMA;
                    we_d        = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    mem_we_d    = dma_we && LOAD_IS_LAST;
                    state_d     = BUSY;
                    cnt_load    = 1'b1;
                    starve_d    = '0;
                end
            end
            BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                        else                    dma_rdata_d = mem_rdata;
                    end
                    dma_ack_d = (owner_q == OWN_DMA);
                    state_d   = DONE;
                end else begin
                    // Registered strobe: raise it for the cycle where cnt hits 0.
                    mem_we_d = we_q && (cnt == CW'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_stall = cpu_req && !((state_q == DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model (one in-flight access
// record, grant time, golden memory) predicts every output each cycle; the
// directed scenarios add literal expectations; a WAIT_CYCLES=1 instance is
// exercised with back-to-back loads.
module tb_dmem_arbiter;

    localparam int W = 2;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] mem [64];

    // second instance, WAIT_CYCLES=1, loads only
    logic        cpu_req1, cpu_stall1, dma_ack1, mem_we1;
    logic        lo1 = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic [31:0] cpu_addr1, cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [31:0] mem1 [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(S)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(S)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req1), .cpu_we(lo1), .cpu_addr(cpu_addr1), .cpu_wdata(z32),
        .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .dma_req(lo1), .dma_we(lo1), .dma_addr(z32), .dma_wdata(z32),
        .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
    );

    // DataMem models: combinational read, write on the clock edge
    assign mem_rdata  = mem[mem_addr[7:2]];
    assign mem_rdata1 = mem1[mem_addr1[7:2]];
    always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr[7:2]] <= mem_wdata;
    always @(posedge clk) if (mem_we1 === 1'b1) mem1[mem_addr1[7:2]] <= mem_wdata1;

    int we_cnt = 0;
    always @(posedge clk) if (mem_we === 1'b1) we_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    function automatic logic [31:0] pat1(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2) * 32'h0101;
    endfunction

    // ---------------- reference model ----------------
    // An access granted in cycle g occupies cycles g+1..g+W (memory held,
    // write in g+W) and completes in g+W+1. cyc is the index of the current cycle.
    bit          model_ok = 1'b0;
    int          cyc = 0;
    bit          m_act = 1'b0, m_dma, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_start;
    int          m_starve = 0;
    logic [31:0] e_mem_addr, e_mem_wdata, e_cpu_rdata, e_dma_rdata;
    logic [31:0] ref_mem [64];

    always @(posedge clk) begin
        int age;
        age = cyc - m_start;
        if (rst) begin
            // a strobe already on the bus during this cycle still lands in memory
            if (m_act && age == W && m_we) ref_mem[m_addr[7:2]] = m_wdata;
            m_act = 1'b0; m_starve = 0;
            e_mem_addr = '0; e_mem_wdata = '0; e_cpu_rdata = '0; e_dma_rdata = '0;
            model_ok = 1'b1;
        end else if (m_act) begin
            if (age == W) begin
                if (m_we)       ref_mem[m_addr[7:2]] = m_wdata;
                else if (m_dma) e_dma_rdata = ref_mem[m_addr[7:2]];
                else            e_cpu_rdata = ref_mem[m_addr[7:2]];
            end
            if (age == W + 1) m_act = 1'b0;
        end else if (cpu_req && (!dma_req || m_starve < S)) begin
            m_act = 1'b1; m_dma = 1'b0; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            m_start = cyc; m_starve = dma_req ? m_starve + 1 : 0;
            e_mem_addr = cpu_addr; e_mem_wdata = cpu_wdata;
        end else if (dma_req) begin
            m_act = 1'b1; m_dma = 1'b1; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
            m_start = cyc; m_starve = 0;
            e_mem_addr = dma_addr; e_mem_wdata = dma_wdata;
        end else begin
            m_starve = 0;
        end
        cyc++;
    end

    // compare process: every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        int age;
        bit done;
        if (model_ok) begin
            age  = cyc - m_start;
            done = m_act && (age == W + 1);
            chk1("cpu_stall", cpu_stall, cpu_req && !(done && !m_dma));
            chk1("dma_ack", dma_ack, done && m_dma);
            chk1("mem_we", mem_we, m_act && (age == W) && m_we);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
            chk("dma_rdata", dma_rdata, e_dma_rdata);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                              output int stalls, output logic [31:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        stalls = 0; rd = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin rd = cpu_rdata; break; end
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dma_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input bit drop, output int lat, output logic [31:0] rd);
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        lat = 0; rd = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma_ack) begin rd = dma_rdata; break; end
            lat++;
            @(posedge clk); #1;
            if (drop && lat == 1) dma_req = 1'b0;
        end
        @(posedge clk); #1;
        dma_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, l, ncomp, last, n;
        logic [31:0] rd;
        logic [4:0]  code;
        bit          cpu_free, dma_free;

        for (int i = 0; i < 64; i++) begin
            mem[i] = '0; ref_mem[i] = '0; mem1[i] = pat1(32'(i) << 2);
        end
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; cpu_req1 = 0; cpu_addr1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_cpu_rdata", cpu_rdata, 32'h0);
        chk1("reset_dma_ack", dma_ack, 1'b0);
        @(posedge clk); #1;

        // 1: CPU store then load
        we_cnt = 0;
        cpu_access(1'b1, 32'h10, 32'hDEAD_BEEF, s, rd);
        chk("t1_store_stall_cycles", 32'(s), 32'd3);
        chk("t1_store_we_pulses", 32'(we_cnt), 32'd1);
        cpu_access(1'b0, 32'h10, 32'h0, s, rd);
        chk("t1_load_latency", 32'(s + 1), 32'd4);
        chk("t1_load_data", rd, 32'hDEAD_BEEF);

        // 2: DMA only
        we_cnt = 0;
        dma_access(1'b1, 32'h20, 32'h1234_5678, 1'b0, l, rd);
        chk("t2_write_ack_latency", 32'(l + 1), 32'd4);
        chk("t2_write_we_pulses", 32'(we_cnt), 32'd1);
        dma_access(1'b0, 32'h20, 32'h0, 1'b0, l, rd);
        chk("t2_read_data", rd, 32'h1234_5678);

        // 3: contention, completion order encoded 1=DMA (oldest in MSB)
        code = '0; ncomp = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'hA5A5_0001;
        for (int i = 0; i < 60 && ncomp < 5; i++) begin
            bit acked;
            @(negedge clk);
            acked = dma_ack;
            if (dma_ack)         begin code = {code[3:0], 1'b1}; ncomp++; end
            else if (!cpu_stall) begin code = {code[3:0], 1'b0}; ncomp++; end
            @(posedge clk); #1;
            if (acked) dma_req = 1'b0;
            if (ncomp == 5) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("t3_completions", 32'(ncomp), 32'd5);
        chk("t3_grant_order", 32'(code), 32'b00010);
        chk("t3_dma_wrote", mem[9], 32'hA5A5_0001);

        // 4: DMA drops request right after grant
        we_cnt = 0;
        dma_access(1'b1, 32'h28, 32'h0BAD_F00D, 1'b1, l, rd);
        chk("t4_ack_latency", 32'(l + 1), 32'd4);
        chk("t4_we_pulses", 32'(we_cnt), 32'd1);
        chk("t4_mem", mem[10], 32'h0BAD_F00D);

        // 5: reset in the first BUSY cycle of a store
        we_cnt = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("t5_no_write", 32'(we_cnt), 32'd0);
        cpu_access(1'b0, 32'h30, 32'h0, s, rd);
        chk("t5_regrant_stall", 32'(s), 32'd3);
        chk("t5_old_value", rd, 32'h0);

        // 6: WAIT_CYCLES=1 back-to-back loads
        cpu_req1 = 1'b1; cpu_addr1 = 32'h40; n = 0; last = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (!cpu_stall1) begin
                chk("t6_rdata", cpu_rdata1, pat1(cpu_addr1));
                chk("t6_mem_addr", mem_addr1, cpu_addr1);
                if (n > 0) chk("t6_period", 32'(i - last), 32'd3);
                last = i; n++;
                @(posedge clk); #1;
                cpu_addr1 = cpu_addr1 + 32'h4;
            end else begin
                @(posedge clk); #1;
            end
        end
        cpu_req1 = 1'b0;
        chk("t6_count", 32'(n), 32'd4);
        chk1("t6_no_write", mem_we1, 1'b0);

        // random phase: protocol-respecting requesters, occasional drops/resets
        cpu_free = 1; dma_free = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cpu_free = !cpu_stall;
            dma_free = !dma_req || dma_ack;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            if (cpu_free || $urandom_range(0, 49) == 0) begin
                cpu_req = ($urandom_range(0, 1) == 1); cpu_we = ($urandom_range(0, 1) == 1);
                cpu_addr = rnd_addr(); cpu_wdata = $urandom;
            end
            if (dma_free || $urandom_range(0, 49) == 0) begin
                dma_req = ($urandom_range(0, 3) == 0); dma_we = ($urandom_range(0, 1) == 1);
                dma_addr = rnd_addr(); dma_wdata = $urandom;
            end
        end
        rst = 0; cpu_req = 0; dma_req = 0;
        repeat (8) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and a secondary master such as a loader or DMA (DMA port).
- Inserts a configurable number of memory wait states on every access.
- Stalls the pipeline while a CPU access is pending.
- CPU has priority; a starvation guard guarantees the DMA port progress.

Parameters:
- WAIT_CYCLES, 1, cycles the memory address/data are held per access (>=1).
- STARVE_LIMIT, 4, consecutive CPU grants made while DMA is waiting before DMA is forced to win (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  MEM stage requests an access this cycle (wmem or m2reg active)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address (ALU result)
- cpu_wdata  in  32  store data (qb)
- cpu_rdata  out  32  load data, valid while cpu_stall=0 and cpu_req=1
- cpu_stall  out  1  freeze IF..MEM stages
- dma_req  in  1  DMA request; held until dma_ack
- dma_we  in  1  1 = write
- dma_addr  in  32  address
- dma_wdata  in  32  write data
- dma_rdata  out  32  read data, valid with dma_ack
- dma_ack  out  1  one-cycle completion pulse
- mem_addr  out  32  to DataMem address
- mem_wdata  out  32  to DataMem write data
- mem_we  out  1  to DataMem write enable
- mem_rdata  in  32  DataMem combinational read data

Behaviour:
- States:
  - IDLE: arbitrate.
  - BUSY: access in progress; a wait counter counts WAIT_CYCLES cycles.
  - DONE: completion cycle.
- All transitions occur on the rising edge of clk.
- IDLE:
  - If cpu_req=1 and (dma_req=0 or starve_cnt<STARVE_LIMIT), grant CPU.
  - Else if dma_req=1, grant DMA.
  - On a grant, latch owner, we, addr and wdata into internal registers; next state BUSY, wait counter = WAIT_CYCLES-1.
  - With no request, remain in IDLE.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched we, asserted only in the final BUSY cycle (counter==0), so exactly one write per access.
  - Counter decrements each cycle. At counter==0, if the access is a read, mem_rdata is captured into cpu_rdata or dma_rdata according to owner; next state is DONE.
  - A write leaves the rdata registers unchanged.
- DONE:
  - If owner=CPU, cpu_stall deasserts for this cycle so the pipeline advances.
  - If owner=DMA, dma_ack=1 for this cycle.
  - No grant is made in DONE; the next state is always IDLE.
- cpu_stall = cpu_req & ~(state==DONE & owner==CPU); this is the only combinational output.
- CPU access latency is WAIT_CYCLES+2 cycles from cpu_req rising to stall low.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on each CPU grant made while dma_req=1.
  - Clears on a DMA grant, or in any IDLE cycle with dma_req=0.
- In IDLE and DONE, mem_we=0 and mem_addr/mem_wdata hold their last values.
- Requester drops its request mid-access: the access completes unchanged. For the DMA, dma_ack still pulses; for the CPU, stall is already 0.
- Simultaneous cpu_req and dma_req with starve_cnt==STARVE_LIMIT: DMA wins, and cpu_stall stays 1 throughout the DMA access.
- Reset:
  - While rst=1 at a clock edge: state=IDLE, starve_cnt=0, owner=CPU, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dma_rdata=0, dma_ack=0.
  - Reset mid-access aborts the access with no write and no ack.
  - cpu_stall follows cpu_req while in reset.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, BUSY, DONE}
  - owner enum {OWN_CPU, OWN_DMA}
  - ADDR_W=32, DATA_W=32
- Natural sub-module: dmem_wait_counter, a loadable down-counter with a zero flag, parameterised by WAIT_CYCLES.

Test Plan (WAIT_CYCLES=2, STARVE_LIMIT=3 unless noted):
1. CPU store then load. Hold cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF.
   - cpu_stall is 1 for 3 cycles, then 0 for 1.
   - mem_we is high exactly once.
   - The following load of 0x10 returns cpu_rdata=0xDEADBEEF with 4-cycle latency.
2. DMA only. Write 0x20=0x12345678 -> dma_ack pulses once, 4 cycles after the request. A DMA read of 0x20 -> dma_rdata=0x12345678 with the ack.
3. Contention. cpu_req held high for 5 back-to-back accesses, dma_req held high.
   - Grant order: CPU, CPU, CPU, DMA, CPU.
   - starve_cnt returns to 0 after the DMA grant.
   - cpu_stall stays 1 through the DMA access.
4. Request drop. Deassert dma_req one cycle after grant -> access completes, dma_ack still pulses, exactly one mem_we pulse.
5. Reset mid-access. Assert rst in the first BUSY cycle of a CPU store to 0x30 (old value 0x0) -> no mem_we, 0x30 reads back 0x0. The state returns to IDLE, and the next request is granted normally.
6. WAIT_CYCLES=1 build. Back-to-back CPU loads -> one access every 3 cycles, mem_addr stable for 1 cycle per access.
